// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with true LRU.
// On halt it flushes every dirty line and then stores the hit count to HITCT_ADDR.
module dcache_assoc #(
  parameter int          WAYS       = 2,
  parameter int          SETS       = 8,
  parameter int          WORDS      = 2,
  parameter logic [31:0] HITCT_ADDR = 32'h00003100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int OB  = $clog2(WORDS);
  localparam int IB  = $clog2(SETS);
  localparam int TW  = 30 - OB - IB;
  localparam int OBW = (OB > 0) ? OB : 1;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AW  = WW;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, HITCT, DONE} state_t;

  logic            valid_q [SETS][WAYS];
  logic            dirty_q [SETS][WAYS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [AW-1:0]   age_q   [SETS][WAYS];
  logic [31:0]     data_q  [SETS][WAYS][WORDS];

  state_t          state_q;
  logic [IB-1:0]   missIdx_q;
  logic [TW-1:0]   missTag_q;
  logic [WW-1:0]   victim_q;
  logic [OBW-1:0]  wc_q;
  logic [IB-1:0]   scanSet_q;
  logic [WW-1:0]   scanWay_q;
  logic [31:0]     hitCount_q;
  logic            refill_q;

  logic            req;
  logic [OBW-1:0]  reqOff;
  logic [IB-1:0]   reqIdx;
  logic [TW-1:0]   reqTag;
  logic            hit;
  logic [WW-1:0]   hitWay;
  logic [WW-1:0]   victim;
  logic            anyInvalid;
  logic            scanDirty;
  logic            lastWord;
  logic            lastScan;

  function automatic logic [31:0] mkAddr(input logic [TW-1:0] t, input logic [IB-1:0] i,
                                         input logic [OBW-1:0] o);
    logic [31:0] a;
    a = (32'(t) << (2 + OB + IB)) | (32'(i) << (2 + OB));
    if (OB > 0) a = a | (32'(o) << 2);
    return a;
  endfunction

  assign req    = dmemREN | dmemWEN;
  assign reqOff = (OB > 0) ? OBW'(dmemaddr[31:2]) : '0;
  assign reqIdx = IB'(dmemaddr >> (2 + OB));
  assign reqTag = TW'(dmemaddr >> (2 + OB + IB));

  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[reqIdx][w] && (tag_q[reqIdx][w] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WW'(w);
      end
    end
  end

  // Prefer the lowest-index empty way; only evict the oldest line when the set is full.
  always_comb begin
    victim     = '0;
    anyInvalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[reqIdx][w]) begin
        victim     = WW'(w);
        anyInvalid = 1'b1;
      end
    end
    if (!anyInvalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[reqIdx][w] == AW'(WAYS - 1)) victim = WW'(w);
      end
    end
  end

  assign scanDirty = valid_q[scanSet_q][scanWay_q] && dirty_q[scanSet_q][scanWay_q];
  assign lastWord  = (wc_q == OBW'(WORDS - 1));
  assign lastScan  = (scanSet_q == IB'(SETS - 1)) && (scanWay_q == WW'(WAYS - 1));

  assign dhit     = (state_q == IDLE) && req && hit;
  assign dmemload = dhit ? data_q[reqIdx][hitWay][reqOff] : '0;
  assign flushed  = (state_q == DONE);

  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = '0;
    dstore = '0;
    case (state_q)
      WB: begin
        dWEN   = 1'b1;
        daddr  = mkAddr(tag_q[missIdx_q][victim_q], missIdx_q, wc_q);
        dstore = data_q[missIdx_q][victim_q][wc_q];
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = mkAddr(missTag_q, missIdx_q, wc_q);
      end
      FLUSH: begin
        if (scanDirty) begin
          dWEN   = 1'b1;
          daddr  = mkAddr(tag_q[scanSet_q][scanWay_q], scanSet_q, wc_q);
          dstore = data_q[scanSet_q][scanWay_q][wc_q];
        end
      end
      HITCT: begin
        dWEN   = 1'b1;
        daddr  = HITCT_ADDR;
        dstore = hitCount_q;
      end
      default: ;
    endcase
  end

  // Single controller: storage arrays, LRU ages, miss handling and the halt flush sequence.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= AW'(w);
          for (int k = 0; k < WORDS; k++) data_q[s][w][k] <= '0;
        end
      end
      state_q    <= IDLE;
      missIdx_q  <= '0;
      missTag_q  <= '0;
      victim_q   <= '0;
      wc_q       <= '0;
      scanSet_q  <= '0;
      scanWay_q  <= '0;
      hitCount_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dhit) begin
            if (dmemWEN) begin
              data_q[reqIdx][hitWay][reqOff] <= dmemstore;
              dirty_q[reqIdx][hitWay]        <= 1'b1;
            end
            for (int v = 0; v < WAYS; v++) begin
              if (age_q[reqIdx][v] < age_q[reqIdx][hitWay])
                age_q[reqIdx][v] <= age_q[reqIdx][v] + 1'b1;
            end
            age_q[reqIdx][hitWay] <= '0;
            // The completion right after a refill is the original miss, not a hit.
            if (refill_q) refill_q   <= 1'b0;
            else          hitCount_q <= hitCount_q + 32'd1;
          end else if (req) begin
            missIdx_q <= reqIdx;
            missTag_q <= reqTag;
            victim_q  <= victim;
            wc_q      <= '0;
            if (valid_q[reqIdx][victim] && dirty_q[reqIdx][victim]) begin
              state_q <= WB;
            end else begin
              valid_q[reqIdx][victim] <= 1'b0;
              state_q                 <= FILL;
            end
          end else if (halt) begin
            scanSet_q <= '0;
            scanWay_q <= '0;
            wc_q      <= '0;
            state_q   <= FLUSH;
          end
        end
        WB: begin
          if (!dwait) begin
            if (lastWord) begin
              wc_q                        <= '0;
              valid_q[missIdx_q][victim_q] <= 1'b0;
              dirty_q[missIdx_q][victim_q] <= 1'b0;
              state_q                      <= FILL;
            end else begin
              wc_q <= wc_q + 1'b1;
            end
          end
        end
        FILL: begin
          if (!dwait) begin
            data_q[missIdx_q][victim_q][wc_q] <= dload;
            if (lastWord) begin
              wc_q                         <= '0;
              tag_q[missIdx_q][victim_q]   <= missTag_q;
              valid_q[missIdx_q][victim_q] <= 1'b1;
              dirty_q[missIdx_q][victim_q] <= 1'b0;
              for (int v = 0; v < WAYS; v++) begin
                if (age_q[missIdx_q][v] < age_q[missIdx_q][victim_q])
                  age_q[missIdx_q][v] <= age_q[missIdx_q][v] + 1'b1;
              end
              age_q[missIdx_q][victim_q] <= '0;
              refill_q                   <= 1'b1;
              state_q                    <= IDLE;
            end else begin
              wc_q <= wc_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!scanDirty || (!dwait && lastWord)) begin
            wc_q                           <= '0;
            valid_q[scanSet_q][scanWay_q] <= 1'b0;
            dirty_q[scanSet_q][scanWay_q] <= 1'b0;
            if (lastScan) begin
              state_q <= HITCT;
            end else if (scanWay_q == WW'(WAYS - 1)) begin
              scanWay_q <= '0;
              scanSet_q <= scanSet_q + 1'b1;
            end else begin
              scanWay_q <= scanWay_q + 1'b1;
            end
          end else if (!dwait) begin
            wc_q <= wc_q + 1'b1;
          end
        end
        HITCT: begin
          if (!dwait) state_q <= DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
Parametrised write-back, write-allocate data cache with N-way set associativity, multi-word blocks and true LRU replacement. It sits between the datapath memory port and the memory controller. On halt it flushes all dirty lines, then stores the hit counter to a fixed address and raises flushed. It supersedes the fixed 2-way, 8-set, 2-word dcache.

Parameters:
WAYS, 2, associativity; legal values 1, 2, 4.
SETS, 8, number of sets; power of 2, at least 2.
WORDS, 2, 32-bit words per block; power of 2, at least 1.
HITCT_ADDR, 32'h00003100, word address that receives the hit count at the end of a flush.

Ports:
CLK  in  1  clock
nRST  in  1  reset
dmemREN  in  1  datapath read request
dmemWEN  in  1  datapath write request
dmemaddr  in  32  datapath word address; bits [1:0] ignored
dmemstore  in  32  datapath write data
halt  in  1  request flush; level, held until flushed
dhit  out  1  access completes this cycle
dmemload  out  32  read data, valid when dhit=1
flushed  out  1  flush and hit-count store complete; sticky
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address
dstore  out  32  memory write data
dwait  in  1  memory busy; a transfer completes in a cycle where the request is high and dwait=0
dload  in  32  memory read data, valid when dREN=1 and dwait=0

Behaviour:
- Reset: nRST, asynchronous, active-low; clock CLK. On reset, all valid, dirty, tag and data bits = 0; ages = way index; hit counter = 0; FSM = IDLE; all outputs = 0.
- Address split: OB = log2(WORDS), IB = log2(SETS).
  - offset = addr[2+OB-1:2], or none when WORDS=1.
  - index = addr[2+OB+IB-1:2+OB].
  - tag = addr[31:2+OB+IB].
- Request precedence: dmemWEN wins over dmemREN if both are high.
- Hit (IDLE only): a way is valid and its tag matches. dhit and dmemload are combinational in the same cycle.
  - Write hit: word and dirty bit are updated at the next posedge.
  - dhit=0 in every state other than IDLE.
- LRU: per set, one log2(WAYS)-bit age per way, 0 = most recent. Ages in a set are always a permutation of 0..WAYS-1.
  - On a hit or fill-complete to way w: ages below age(w) increment, then age(w) becomes 0.
- Victim: lowest-index invalid way; otherwise the way with age WAYS-1.
- FSM states: IDLE, WB, FILL, FLUSH, HITCT, DONE.
  - IDLE, miss and !halt: go to WB if the victim is valid and dirty, else FILL. The word counter wc resets to 0.
  - IDLE, halt and no request pending: go to FLUSH with set/way scan = 0. halt with a request pending services the request first.
  - WB: dWEN=1, daddr = {victim tag, index, wc, 2'b00}, dstore = victim word wc. wc increments on each completion. After word WORDS-1 completes: go to FILL, wc=0.
  - FILL: dREN=1, daddr = {req tag, index, wc, 2'b00}. On completion, dload is written into the victim word wc.
    - On the last word: tag is written, valid=1, dirty=0, ages are updated, and a refill flag is set. Next state is IDLE, where the held request now hits.
  - FLUSH: the scan visits (set, way) in order set-major, way-minor.
    - Valid and dirty line: write WORDS words as in WB, then clear valid and dirty.
    - Other lines: clear valid in 1 cycle.
    - After the last set/way: go to HITCT.
  - HITCT: dWEN=1, daddr=HITCT_ADDR, dstore = hit counter. On completion go to DONE.
  - DONE: flushed=1 and no memory requests until reset.
- Hit counter: 32 bits, wraps. Increments on each dhit cycle unless the refill flag is set. A dhit clears the refill flag, so the post-fill completion is not counted as a hit.
- Memory requests hold stable address and data while dwait=1. No request is ever abandoned except by reset.
- Reset mid-WB, mid-FILL or mid-FLUSH aborts immediately. The partially filled line stays invalid.

Test Plan:
1. Cold read at 0x40, default parameters, dwait low after 2 cycles per word.
   -> dREN at 0x40, then 0x44; then dhit=1 with dmemload = mem[0x40]; hit counter unchanged.
   - Re-read 0x44 -> dhit in the same cycle, counter = 1.
2. Write 0xDEAD to 0x40 (hit), then read misses at 0x80 and 0xC0 mapping to set 0.
   -> the second miss writes back 0x40/0x44 with 0xDEAD first, then fills 0xC0/0xC4.
3. WAYS=4: fill ways with tags A, B, C, D; hit A; miss E.
   -> victim is B; B is not written back if clean; later access to B misses.
4. halt with dirty lines in set 0 way 1 and set 5 way 0.
   -> exactly 2×WORDS dWEN writes in scan order, then one write of the hit count to 0x3100, then flushed=1 held.
5. dwait held high for 10 cycles mid-FILL.
   -> daddr and dREN stable; no dhit; fill completes correctly afterwards.
6. nRST asserted during FILL word 1.
   -> all outputs 0 immediately; following read of the same address misses again.
